// File: rtl/rowmax_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rowmax_pkg
// Brief   : Shared types and constants for the row-maximum sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package rowmax_pkg;

    localparam int SMAX_LANES = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Most negative two's-complement value for a w-bit element.
    function automatic logic [63:0] signed_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rowmax_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rowmax_ctrl
// Brief   : Streams one score row chunk by chunk through a shared 16-lane
//           max engine and folds the chunk results into the row maximum.
//           Optional ROWMAX_ARGMAX_EN adds O_ROW_MAX_IDX (winning chunk).
// Revision: 1.0 - initial release
// ============================================================================
module rowmax_ctrl
    import rowmax_pkg::*;
#(
    parameter  int D_W     = 16,
    parameter  int N_CHUNK = 4,
    localparam int CW      = $clog2(N_CHUNK),
    localparam int LW      = $clog2(N_CHUNK + 1)
) (
    input  logic                                I_CLK,
    input  logic                                I_RST,
    input  logic                                I_START,
    input  logic [LW-1:0]                       I_LEN,
    output logic                                O_BUSY,
    output logic                                O_RD_EN,
    output logic [CW-1:0]                       O_RD_ADDR,
    input  logic [0:SMAX_LANES-1][D_W-1:0]      I_RD_DATA,
    output logic                                O_SM_ENA,
    output logic [0:SMAX_LANES-1][D_W-1:0]      O_SM_DATA,
    input  logic                                I_SM_VLD,
    input  logic [D_W-1:0]                      I_SM_MAX,
    output logic                                O_DONE,
    output logic [D_W-1:0]                      O_ROW_MAX
`ifdef ROWMAX_ARGMAX_EN
    ,
    output logic [CW-1:0]                       O_ROW_MAX_IDX
`endif
);

    localparam logic [63:0]    C_SMIN_FULL = signed_min(D_W);
    localparam logic [D_W-1:0] C_SMIN      = C_SMIN_FULL[D_W-1:0];
    localparam logic [LW-1:0]  C_NCHUNK    = LW'(N_CHUNK);

    state_t                             state_q;
    logic [LW-1:0]                      len_q;
    logic [CW-1:0]                      chunk_q;
    logic                               first_q;
    logic                               busy_q;
    logic                               rd_en_q;
    logic                               sm_ena_q;
    logic [0:SMAX_LANES-1][D_W-1:0]     sm_data_q;
    logic                               done_q;
    logic [D_W-1:0]                     run_max_q;
    logic [D_W-1:0]                     row_max_q;

    logic [LW-1:0]                      len_d;
    logic [D_W-1:0]                     run_max_d;
    logic                               w_take;
    logic                               w_vld;
    logic                               w_last;

`ifdef ROWMAX_ARGMAX_EN
    logic [CW-1:0]                      run_idx_q;
    logic [CW-1:0]                      row_idx_q;
    logic [CW-1:0]                      run_idx_d;
`endif

    always_comb begin
        len_d     = (I_LEN > C_NCHUNK) ? C_NCHUNK : I_LEN;
        w_take    = first_q || ($signed(I_SM_MAX) > $signed(run_max_q));
        run_max_d = w_take ? I_SM_MAX : run_max_q;
        // The first WAIT cycle coincides with ENA; a VLD seen then is left
        // over from the previous operation, since the engine clears it only
        // on the edge that accepts ENA.
        w_vld     = (state_q == S_WAIT) && !sm_ena_q && I_SM_VLD;
        w_last    = (LW'(chunk_q) == (len_q - LW'(1)));
`ifdef ROWMAX_ARGMAX_EN
        run_idx_d = w_take ? chunk_q : run_idx_q;
`endif
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            chunk_q   <= '0;
            first_q   <= 1'b0;
            busy_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            sm_ena_q  <= 1'b0;
            sm_data_q <= '0;
            done_q    <= 1'b0;
            run_max_q <= '0;
            row_max_q <= '0;
`ifdef ROWMAX_ARGMAX_EN
            run_idx_q <= '0;
            row_idx_q <= '0;
`endif
        end else begin
            rd_en_q  <= 1'b0;
            sm_ena_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (I_START) begin
                        len_q   <= len_d;
                        chunk_q <= '0;
                        first_q <= 1'b1;
                        busy_q  <= 1'b1;
                        if (len_d == '0) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            row_max_q <= C_SMIN;
`ifdef ROWMAX_ARGMAX_EN
                            row_idx_q <= '0;
`endif
                        end else begin
                            state_q <= S_RD;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    sm_ena_q  <= 1'b1;
                    sm_data_q <= I_RD_DATA;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_vld) begin
                        run_max_q <= run_max_d;
                        first_q   <= 1'b0;
`ifdef ROWMAX_ARGMAX_EN
                        run_idx_q <= run_idx_d;
`endif
                        if (w_last) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            row_max_q <= run_max_d;
`ifdef ROWMAX_ARGMAX_EN
                            row_idx_q <= run_idx_d;
`endif
                        end else begin
                            chunk_q <= chunk_q + CW'(1);
                            rd_en_q <= 1'b1;
                            state_q <= S_RD;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign O_BUSY    = busy_q;
    assign O_RD_EN   = rd_en_q;
    assign O_RD_ADDR = chunk_q;
    assign O_SM_ENA  = sm_ena_q;
    assign O_SM_DATA = sm_data_q;
    assign O_DONE    = done_q;
    assign O_ROW_MAX = row_max_q;
`ifdef ROWMAX_ARGMAX_EN
    assign O_ROW_MAX_IDX = row_idx_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rowmax_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_rowmax_ctrl
// Brief   : Directed vector bench for rowmax_ctrl with behavioural score
//           buffer and 3-edge max engine. Honours ROWMAX_ARGMAX_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rowmax_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [2:0]         len;
    logic               busy;
    logic               rd_en;
    logic [1:0]         rd_addr;
    logic [0:15][15:0]  rd_data = '0;
    logic               sm_ena;
    logic [0:15][15:0]  sm_data;
    logic               sm_vld = 1'b0;
    logic [15:0]        sm_max = '0;
    logic               done;
    logic [15:0]        row_max;
`ifdef ROWMAX_ARGMAX_EN
    logic [1:0]         row_idx;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rowmax_ctrl #(.D_W(16), .N_CHUNK(4)) dut (
        .I_CLK     (clk),
        .I_RST     (rst),
        .I_START   (start),
        .I_LEN     (len),
        .O_BUSY    (busy),
        .O_RD_EN   (rd_en),
        .O_RD_ADDR (rd_addr),
        .I_RD_DATA (rd_data),
        .O_SM_ENA  (sm_ena),
        .O_SM_DATA (sm_data),
        .I_SM_VLD  (sm_vld),
        .I_SM_MAX  (sm_max),
        .O_DONE    (done),
        .O_ROW_MAX (row_max)
`ifdef ROWMAX_ARGMAX_EN
        ,
        .O_ROW_MAX_IDX (row_idx)
`endif
    );

    // Score buffer: data appears the cycle after the read strobe.
    logic [0:3][0:15][15:0] mem = '0;
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    function automatic logic [15:0] lane_max(input logic [0:15][15:0] d);
        logic signed [15:0] m;
        m = d[0];
        for (int i = 1; i < 16; i++) if ($signed(d[i]) > m) m = d[i];
        return m;
    endfunction

    // Max engine: ENA taken at E0 clears VLD, result visible after E0+2.
    int          eng_cnt = 0;
    logic [15:0] eng_pend = '0;
    always @(posedge clk) begin
        if (sm_ena) begin
            sm_vld   <= 1'b0;
            eng_cnt  <= 2;
            eng_pend <= lane_max(sm_data);
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                sm_vld <= 1'b1;
                sm_max <= eng_pend;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},    32'(busy),    0);
        chk({tag, "_rd_en"},   32'(rd_en),   0);
        chk({tag, "_sm_ena"},  32'(sm_ena),  0);
        chk({tag, "_done"},    32'(done),    0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_sm_data"}, (sm_data === '0) ? 32'd0 : 32'd1, 0);
        chk({tag, "_row_max"}, 32'(row_max), 0);
    endtask

    typedef struct {
        logic [2:0]             len;
        bit                     poke;
        logic [0:3][0:15][15:0] data;
        int                     exp_done;
        logic [15:0]            exp_max;
        logic [1:0]             exp_idx;
        int                     exp_rd;
    } vec_t;

    vec_t vt [7];

    task automatic set_chunk(input int v, input int k, input int top);
        for (int i = 0; i < 16; i++) vt[v].data[k][i] = 16'(top - i);
    endtask

    // Starts a row at the current cycle (cycle 0) and observes 40 cycles.
    task automatic run_row(input logic [2:0] l, input bit poke, input logic [15:0] exp_max,
                           input int exp_done, input int exp_rd, input logic [1:0] exp_idx,
                           input string tag);
        int          done_cyc;
        int          n_rd, n_ena, n_done, n_busy, n_addr_bad, n_overlap;
        logic [15:0] cap_max;
        logic [1:0]  cap_idx;
        done_cyc = -1;
        n_rd = 0; n_ena = 0; n_done = 0; n_busy = 0; n_addr_bad = 0; n_overlap = 0;
        cap_max = '0;
        cap_idx = '0;
        len   = l;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (rd_en) begin
                if (32'(rd_addr) != 32'(n_rd)) n_addr_bad++;
                n_rd++;
            end
            if (sm_ena) n_ena++;
            if (rd_en && sm_ena) n_overlap++;
            if (busy) n_busy++;
            start = 1'b0;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    cap_max  = row_max;
`ifdef ROWMAX_ARGMAX_EN
                    cap_idx  = row_idx;
`endif
                end
                if (poke) start = 1'b1;
            end
            if (poke && c == 4) start = 1'b1;
        end
        chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
        chk({tag, "_done_count"}, 32'(n_done), 1);
        chk({tag, "_row_max"},    32'(cap_max), 32'(exp_max));
        chk({tag, "_max_held"},   32'(row_max), 32'(exp_max));
        chk({tag, "_reads"},      32'(n_rd), 32'(exp_rd));
        chk({tag, "_issues"},     32'(n_ena), 32'(exp_rd));
        chk({tag, "_addr_order"}, 32'(n_addr_bad), 0);
        chk({tag, "_rd_ena_overlap"}, 32'(n_overlap), 0);
        chk({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_done));
        chk({tag, "_idle_after"}, 32'(busy), 0);
`ifdef ROWMAX_ARGMAX_EN
        chk({tag, "_idx"},        32'(cap_idx), 32'(exp_idx));
`else
        if (cap_idx !== '0) chk({tag, "_idx_unused"}, 32'(cap_idx), 0);
`endif
    endtask

    initial begin
        for (int v = 0; v < 7; v++) begin
            vt[v].data = '0;
            vt[v].poke = 1'b0;
        end
        // lanes -3..12
        vt[0].len = 3'd1; vt[0].exp_done = 7;  vt[0].exp_max = 16'h000C; vt[0].exp_idx = 2'd0; vt[0].exp_rd = 1;
        for (int i = 0; i < 16; i++) vt[0].data[0][i] = 16'(i - 3);
        // chunk maxima 5, 7FFF, -1, 7FFF: tie keeps chunk 1
        vt[1].len = 3'd4; vt[1].exp_done = 25; vt[1].exp_max = 16'h7FFF; vt[1].exp_idx = 2'd1; vt[1].exp_rd = 4;
        set_chunk(1, 0, 5); set_chunk(1, 1, 32767); set_chunk(1, 2, -1); set_chunk(1, 3, 32767);
        // all lanes at the signed minimum
        vt[2].len = 3'd3; vt[2].exp_done = 19; vt[2].exp_max = 16'h8000; vt[2].exp_idx = 2'd0; vt[2].exp_rd = 3;
        for (int k = 0; k < 4; k++) for (int i = 0; i < 16; i++) vt[2].data[k][i] = 16'h8000;
        // I_LEN=7 clamps to 4, all negative, max -7 in chunk 1
        vt[3].len = 3'd7; vt[3].exp_done = 25; vt[3].exp_max = 16'hFFF9; vt[3].exp_idx = 2'd1; vt[3].exp_rd = 4;
        set_chunk(3, 0, -50); set_chunk(3, 1, -7); set_chunk(3, 2, -20); set_chunk(3, 3, -9);
        // empty row
        vt[4].len = 3'd0; vt[4].exp_done = 1;  vt[4].exp_max = 16'h8000; vt[4].exp_idx = 2'd0; vt[4].exp_rd = 0;
        // stray starts in WAIT and DONE; tied chunk maxima
        vt[5].len = 3'd2; vt[5].poke = 1'b1; vt[5].exp_done = 13; vt[5].exp_max = 16'h012C; vt[5].exp_idx = 2'd0; vt[5].exp_rd = 2;
        set_chunk(5, 0, 300); set_chunk(5, 1, 300);
        // later chunk is larger unsigned but smaller signed
        vt[6].len = 3'd2; vt[6].exp_done = 13; vt[6].exp_max = 16'h0064; vt[6].exp_idx = 2'd0; vt[6].exp_rd = 2;
        set_chunk(6, 0, 100); set_chunk(6, 1, -200);

        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            mem = vt[v].data;
            run_row(vt[v].len, vt[v].poke, vt[v].exp_max, vt[v].exp_done,
                    vt[v].exp_rd, vt[v].exp_idx, $sformatf("vec%0d", v));
        end

        // Reset during the second WAIT of a len=2 row.
        mem = '0;
        for (int i = 0; i < 16; i++) begin
            mem[0][i] = 16'(500 - i);
            mem[1][i] = 16'(600 - i);
        end
        len   = 3'd2;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 10) begin
                chk("pre_reset_busy", 32'(busy), 1);
                rst = 1'b1;
            end
            if (c == 11) chk_zero("midrst_a");
            if (c == 12) begin
                chk_zero("midrst_b");
                rst = 1'b0;
            end
        end

        mem = '0;
        for (int i = 0; i < 16; i++) mem[0][i] = 16'(42 - i);
        run_row(3'd1, 1'b0, 16'd42, 7, 1, 2'd0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
